// File: rtl/ysyx_25030077_pkg.sv
// Shared types and constants for the ysyx_25030077 fetch unit.
// FSM encoding, halt causes and reset values live here.
package ysyx_25030077_pkg;

  typedef enum logic [1:0] {
    S_REQ   = 2'd0,
    S_WAIT  = 2'd1,
    S_VALID = 2'd2,
    S_HALT  = 2'd3
  } ifu_state_e;

  typedef logic [1:0] fault_t;

  localparam fault_t FAULT_NONE     = 2'd0;
  localparam fault_t FAULT_ILLEGAL  = 2'd1;
  localparam fault_t FAULT_ACCESS   = 2'd2;
  localparam fault_t FAULT_MISALIGN = 2'd3;

  localparam logic [31:0] NOP_INST = 32'h0000_0013;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h8000_0000;

  function automatic logic misaligned(input logic [31:0] a);
    return a[1:0] != 2'b00;
  endfunction

endpackage

// File: rtl/ysyx_25030077_ifu_if.sv
// Fetch unit bus bundle: imem handshake, decode handshake, next-PC
// feedback and status. The IFU is the master side.
interface ysyx_25030077_ifu_if;

  logic        io_imem_req_valid;
  logic        io_imem_req_ready;
  logic [31:0] io_imem_req_addr;
  logic        io_imem_resp_valid;
  logic [31:0] io_imem_resp_data;
  logic        io_imem_resp_err;
  logic        io_inst_valid;
  logic        io_inst_ready;
  logic [31:0] io_instruction;
  logic [31:0] io_pc_count;
  logic [31:0] io_pc_next;
  logic        io_is_unknown_instruction;
  logic        io_halted;
  logic [1:0]  io_fault;
  logic [31:0] io_inst_count;

  modport master (
    output io_imem_req_valid, io_imem_req_addr,
    output io_inst_valid, io_instruction, io_pc_count,
    output io_halted, io_fault, io_inst_count,
    input  io_imem_req_ready, io_imem_resp_valid,
    input  io_imem_resp_data, io_imem_resp_err,
    input  io_inst_ready, io_pc_next,
    input  io_is_unknown_instruction
  );

  modport slave (
    input  io_imem_req_valid, io_imem_req_addr,
    input  io_inst_valid, io_instruction, io_pc_count,
    input  io_halted, io_fault, io_inst_count,
    output io_imem_req_ready, io_imem_resp_valid,
    output io_imem_resp_data, io_imem_resp_err,
    output io_inst_ready, io_pc_next,
    output io_is_unknown_instruction
  );

endinterface

// File: rtl/ysyx_25030077_pc_reg.sv
// Architectural PC register with write-enable.
// Resets asynchronously to the boot address.
module ysyx_25030077_pc_reg
  import ysyx_25030077_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        we,
  input  logic [31:0] pc_d,
  output logic [31:0] pc_q
);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pc_q <= RESET_PC;
    end else if (we) begin
      pc_q <= pc_d;
    end
  end

endmodule

// File: rtl/ysyx_25030077_ifu.sv
// Instruction fetch unit: fetches the word at PC, holds it for decode,
// and commits the next PC on retire or halts with a fault code.
module ysyx_25030077_ifu
  import ysyx_25030077_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic clock,
  input  logic reset,
  ysyx_25030077_ifu_if.master io
);

  ifu_state_e  state_q, state_d;
  logic [31:0] inst_q, inst_d;
  logic [31:0] count_q, count_d;
  fault_t      fault_q, fault_d;
  logic        req_valid_q, req_valid_d;
  logic        inst_valid_q, inst_valid_d;
  logic        halted_q, halted_d;
  logic [31:0] pc_q;
  logic        pc_we;

  ysyx_25030077_pc_reg #(
    .RESET_PC(RESET_PC)
  ) u_pc_reg (
    .clock(clock),
    .reset(reset),
    .we   (pc_we),
    .pc_d (io.io_pc_next),
    .pc_q (pc_q)
  );

  always_comb begin
    state_d = state_q;
    inst_d  = inst_q;
    count_d = count_q;
    fault_d = fault_q;
    pc_we   = 1'b0;
    unique case (state_q)
      S_REQ: begin
        if (io.io_imem_req_ready) state_d = S_WAIT;
      end
      S_WAIT: begin
        if (io.io_imem_resp_valid) begin
          if (io.io_imem_resp_err) begin
            state_d = S_HALT;
            fault_d = FAULT_ACCESS;
          end else begin
            inst_d  = io.io_imem_resp_data;
            state_d = S_VALID;
          end
        end
      end
      S_VALID: begin
        // Illegal instruction outranks a bad target; neither commits.
        if (io.io_inst_ready) begin
          if (io.io_is_unknown_instruction) begin
            state_d = S_HALT;
            fault_d = FAULT_ILLEGAL;
          end else if (misaligned(io.io_pc_next)) begin
            state_d = S_HALT;
            fault_d = FAULT_MISALIGN;
          end else begin
            pc_we   = 1'b1;
            count_d = count_q + 32'd1;
            state_d = S_REQ;
          end
        end
      end
      S_HALT: begin
        state_d = S_HALT;
      end
    endcase
    req_valid_d  = (state_d == S_REQ);
    inst_valid_d = (state_d == S_VALID);
    halted_d     = (state_d == S_HALT);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= S_REQ;
      inst_q       <= NOP_INST;
      count_q      <= 32'd0;
      fault_q      <= FAULT_NONE;
      req_valid_q  <= 1'b1;
      inst_valid_q <= 1'b0;
      halted_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      inst_q       <= inst_d;
      count_q      <= count_d;
      fault_q      <= fault_d;
      req_valid_q  <= req_valid_d;
      inst_valid_q <= inst_valid_d;
      halted_q     <= halted_d;
    end
  end

  assign io.io_imem_req_valid = req_valid_q;
  assign io.io_imem_req_addr  = pc_q;
  assign io.io_inst_valid     = inst_valid_q;
  assign io.io_instruction    = inst_q;
  assign io.io_pc_count       = pc_q;
  assign io.io_halted         = halted_q;
  assign io.io_fault          = fault_q;
  assign io.io_inst_count     = count_q;

endmodule

// File: tb/tb_ysyx_25030077_ifu.sv
// Bench for ysyx_25030077_ifu: random memory/decode stimulus, a
// transaction-level model and a fetch scoreboard.
module tb_ysyx_25030077_ifu;
  import ysyx_25030077_pkg::*;

  localparam logic [31:0] BOOT = 32'h8000_0000;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  ysyx_25030077_ifu_if bus ();

  ysyx_25030077_ifu #(
    .RESET_PC(BOOT)
  ) dut (
    .clock(clock),
    .reset(reset),
    .io   (bus)
  );

  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
  } exp_t;

  exp_t exp_q[$];
  exp_t cur;

  int checks = 0;
  int errors = 0;

  // Model: a fetch is outstanding, a word is held, or the core halted.
  logic [31:0] m_pc = BOOT;
  logic [31:0] m_count = 32'd0;
  logic [1:0]  m_fault = 2'd0;
  bit m_pending = 0, m_avail = 0, m_halted = 0, m_fresh = 0;

  int rdy_pct = 100, rsp_pct = 100, irdy_pct = 100;
  int err_pct = 0, unk_pct = 0, mis_pct = 0;
  int br_pct = 0, loop_pct = 0, spur_pct = 0;
  bit stale = 0, force_pc = 0, fix_data = 0;
  logic [31:0] force_val = 32'd0, data_val = 32'd0;

  task automatic cmp(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic timeout(string name);
    checks++;
    errors++;
    $display("FAIL %s: wait bound expired", name);
  endtask

  function automatic bit pct(int p);
    return int'($urandom % 100) < p;
  endfunction

  // Driver: inputs change 2 time units after each rising edge.
  initial begin
    logic [31:0] r, d;
    bus.io_imem_req_ready = 1'b0;
    bus.io_imem_resp_valid = 1'b0;
    bus.io_imem_resp_data = 32'd0;
    bus.io_imem_resp_err = 1'b0;
    bus.io_inst_ready = 1'b0;
    bus.io_pc_next = BOOT;
    bus.io_is_unknown_instruction = 1'b0;
    forever begin
      @(posedge clock);
      #2;
      bus.io_imem_resp_valid = 1'b0;
      bus.io_imem_resp_err = 1'b0;
      bus.io_imem_resp_data = $urandom;
      if (reset) begin
        bus.io_imem_req_ready = 1'b0;
        bus.io_inst_ready = 1'b0;
        bus.io_is_unknown_instruction = 1'b0;
      end else begin
        bus.io_imem_req_ready = pct(rdy_pct);
        if (m_pending && pct(rsp_pct)) begin
          d = fix_data ? data_val : $urandom;
          bus.io_imem_resp_valid = 1'b1;
          bus.io_imem_resp_data = d;
          bus.io_imem_resp_err = pct(err_pct);
          if (!bus.io_imem_resp_err) exp_q.push_back('{m_pc, d});
        end else if (!m_pending && (stale || pct(spur_pct))) begin
          bus.io_imem_resp_valid = 1'b1;
          bus.io_imem_resp_err = 1'($urandom % 2);
        end
        bus.io_inst_ready = pct(irdy_pct);
        bus.io_is_unknown_instruction = pct(unk_pct);
        r = $urandom;
        r[1:0] = 2'b00;
        if (force_pc) bus.io_pc_next = force_val;
        else if (pct(mis_pct)) bus.io_pc_next = m_pc + 32'd2;
        else if (pct(br_pct)) bus.io_pc_next = r;
        else if (pct(loop_pct)) bus.io_pc_next = m_pc;
        else bus.io_pc_next = m_pc + 32'd4;
      end
    end
  end

  // Monitor: compare the DUT with the model, then apply this cycle's events.
  always @(negedge clock) begin
    bit exp_req;
    if (reset) begin
      m_pc = BOOT;
      m_count = 32'd0;
      m_fault = FAULT_NONE;
      m_pending = 0;
      m_avail = 0;
      m_halted = 0;
      m_fresh = 0;
      exp_q.delete();
    end
    exp_req = !m_pending && !m_avail && !m_halted;
    cmp("req_valid", 32'(bus.io_imem_req_valid), 32'(exp_req));
    if (exp_req) cmp("req_addr", bus.io_imem_req_addr, m_pc);
    cmp("inst_valid", 32'(bus.io_inst_valid), 32'(m_avail));
    cmp("pc_count", bus.io_pc_count, m_pc);
    cmp("halted", 32'(bus.io_halted), 32'(m_halted));
    cmp("fault", 32'(bus.io_fault), 32'(m_fault));
    cmp("inst_count", bus.io_inst_count, m_count);
    if (m_fresh) begin
      m_fresh = 0;
      if (exp_q.size() == 0) begin
        timeout("scoreboard_empty");
      end else begin
        cur = exp_q.pop_front();
        cmp("fetch_pc", bus.io_pc_count, cur.pc);
        cmp("fetch_inst", bus.io_instruction, cur.inst);
      end
    end else if (m_avail) begin
      cmp("inst_stable", bus.io_instruction, cur.inst);
    end
    if (!reset && !m_halted) begin
      if (m_pending) begin
        if (bus.io_imem_resp_valid) begin
          m_pending = 0;
          if (bus.io_imem_resp_err) begin
            m_halted = 1;
            m_fault = FAULT_ACCESS;
          end else begin
            m_avail = 1;
            m_fresh = 1;
          end
        end
      end else if (m_avail) begin
        if (bus.io_inst_ready) begin
          m_avail = 0;
          if (bus.io_is_unknown_instruction) begin
            m_halted = 1;
            m_fault = FAULT_ILLEGAL;
          end else if (bus.io_pc_next[1:0] != 2'b00) begin
            m_halted = 1;
            m_fault = FAULT_MISALIGN;
          end else begin
            m_pc = bus.io_pc_next;
            m_count = m_count + 32'd1;
          end
        end
      end else if (bus.io_imem_req_ready) begin
        m_pending = 1;
      end
    end
  end

  task automatic cyc(int n);
    repeat (n) begin
      @(negedge clock);
      #1;
    end
  endtask

  task automatic do_reset();
    @(posedge clock);
    #1 reset = 1'b1;
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;
  endtask

  task automatic wait_retires(logic [31:0] target, int budget);
    int n = 0;
    while (m_count < target && n < budget) begin
      cyc(1);
      n++;
    end
    if (m_count < target) timeout("retire_wait");
  endtask

  // what: 0 = fetch outstanding, 1 = word held, 2 = halted
  task automatic wait_flag(int what, int budget);
    int n = 0;
    bit hit = 0;
    while (!hit && n < budget) begin
      cyc(1);
      n++;
      hit = (what == 0) ? m_pending : (what == 1) ? m_avail : m_halted;
    end
    if (!hit) timeout("flag_wait");
  endtask

  initial begin
    reset = 1'b1;
    repeat (3) @(posedge clock);
    #1 reset = 1'b0;

    // Back-to-back sequential fetches.
    wait_retires(32'd3, 40);
    rdy_pct = 0;
    rsp_pct = 0;
    irdy_pct = 0;
    fix_data = 1;
    data_val = 32'h0050_0093;
    cyc(1);
    cmp("count_three", bus.io_inst_count, 32'd3);

    // Stalled request and slow response.
    cyc(4);
    rdy_pct = 100;
    wait_flag(0, 10);
    cyc(5);
    rsp_pct = 100;
    wait_flag(1, 10);
    cyc(1);
    cmp("slow_inst", bus.io_instruction, 32'h0050_0093);
    cyc(5);
    cmp("no_retire", bus.io_inst_count, 32'd3);
    fix_data = 0;

    // Taken branch.
    force_pc = 1;
    force_val = 32'h8000_0100;
    irdy_pct = 100;
    wait_retires(32'd4, 10);
    force_pc = 0;
    cyc(1);
    cmp("branch_addr", bus.io_imem_req_addr, 32'h8000_0100);
    cmp("branch_count", bus.io_inst_count, 32'd4);

    // Illegal instruction, then noise while halted.
    unk_pct = 100;
    wait_flag(2, 20);
    cyc(1);
    cmp("ill_fault", 32'(bus.io_fault), 32'(FAULT_ILLEGAL));
    cmp("ill_pc", bus.io_pc_count, 32'h8000_0100);
    unk_pct = 0;
    rdy_pct = 50;
    spur_pct = 50;
    irdy_pct = 50;
    cyc(20);
    cmp("ill_halted", 32'(bus.io_halted), 32'd1);
    spur_pct = 0;
    rdy_pct = 100;
    irdy_pct = 100;

    // Access fault.
    err_pct = 100;
    do_reset();
    wait_flag(2, 20);
    cyc(1);
    cmp("acc_fault", 32'(bus.io_fault), 32'(FAULT_ACCESS));
    err_pct = 0;

    // Misaligned next PC.
    force_pc = 1;
    force_val = 32'h8000_0002;
    do_reset();
    wait_flag(2, 20);
    cyc(1);
    cmp("mis_fault", 32'(bus.io_fault), 32'(FAULT_MISALIGN));
    cmp("mis_count", bus.io_inst_count, 32'd0);
    force_pc = 0;

    // Reset while waiting, stale response afterwards.
    do_reset();
    rsp_pct = 0;
    wait_flag(0, 20);
    rdy_pct = 0;
    stale = 1;
    do_reset();
    cyc(3);
    cmp("stale_pc", bus.io_imem_req_addr, BOOT);
    cmp("stale_req", 32'(bus.io_imem_req_valid), 32'd1);
    stale = 0;
    rdy_pct = 100;
    rsp_pct = 100;
    wait_retires(32'd1, 20);

    // Random segments.
    for (int s = 0; s < 8; s++) begin
      rdy_pct = $urandom_range(30, 100);
      rsp_pct = $urandom_range(30, 100);
      irdy_pct = $urandom_range(30, 100);
      err_pct = $urandom_range(0, 2);
      unk_pct = $urandom_range(0, 2);
      mis_pct = $urandom_range(0, 2);
      br_pct = 15;
      loop_pct = 10;
      spur_pct = 10;
      do_reset();
      cyc(400);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ysyx_25030077_ifu.md
# ysyx_25030077_ifu

Instruction fetch unit: owns the architectural PC register, fetches the instruction word at PC from instruction memory over a valid/ready handshake, and presents `{pc, instruction}` to decode/execute. It sits directly upstream of the next-PC stage: that stage reads `io_pc_count` and `io_instruction` from this block and returns `io_pc_next` and `io_is_unknown_instruction`, which this block commits when the instruction retires.

## Interface
Parameters:
- `RESET_PC`, 32'h8000_0000: PC value loaded on reset.

Ports:
- `clock`  in  1  sole clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `io_imem_req_valid`  out  1  fetch request valid.
- `io_imem_req_ready`  in  1  memory accepts request.
- `io_imem_req_addr`  out  32  fetch address; always equals the current PC.
- `io_imem_resp_valid`  in  1  response word valid.
- `io_imem_resp_data`  in  32  fetched instruction.
- `io_imem_resp_err`  in  1  access fault on this response.
- `io_inst_valid`  out  1  instruction available to decode.
- `io_inst_ready`  in  1  downstream retires the instruction this cycle.
- `io_instruction`  out  32  latched instruction word.
- `io_pc_count`  out  32  PC of `io_instruction`.
- `io_pc_next`  in  32  next PC from the next-PC stage; combinational from `io_pc_count` and `io_instruction`.
- `io_is_unknown_instruction`  in  1  current instruction is illegal.
- `io_halted`  out  1  core stopped.
- `io_fault`  out  2  halt cause: 0 none, 1 illegal instruction, 2 fetch access error, 3 misaligned next PC.
- `io_inst_count`  out  32  number of retired instructions.

## Operation
- FSM states: REQ, WAIT, VALID, HALT. Reset enters REQ.
- REQ:
  - `io_imem_req_valid`=1 and `io_imem_req_addr`=pc.
  - On `req_ready`, go to WAIT.
  - `io_imem_resp_*` are ignored in this state.
- WAIT:
  - `req_valid`=0.
  - On `resp_valid` with `resp_err`=0: latch `resp_data` into the instruction register and go to VALID.
  - On `resp_valid` with `resp_err`=1: go to HALT with `io_fault`=2.
- VALID: `io_inst_valid`=1. On `io_inst_ready`, evaluated with priority:
  - `io_is_unknown_instruction`=1: HALT, fault 1. pc and count are not updated.
  - Else `io_pc_next[1:0]`≠0: HALT, fault 3. pc and count are not updated.
  - Else: pc ← `io_pc_next`, `io_inst_count` += 1 (wraps mod 2^32), go to REQ.
- HALT:
  - Absorbing state; only reset leaves it.
  - `io_halted`=1, all valids 0, pc, instruction and count frozen.
- `io_pc_next`==pc (self-loop) is legal: the same address is refetched.
- `io_instruction` and `io_pc_count` remain stable for the whole time `io_inst_valid` is high.

## Timing
- Reset values (asynchronous, applied immediately on `reset`):
  - pc=`RESET_PC`
  - instruction register=32'h0000_0013 (nop)
  - `io_inst_count`=0, `io_fault`=0, `io_halted`=0
  - `io_inst_valid`=0, `io_imem_req_valid`=1 (state REQ)
- Reset asserted mid-transaction abandons the transaction. A response that arrives after reset deassertion while in REQ is ignored.
- First request appears in the first cycle after reset deasserts.
- Minimum retire loop is 3 cycles per instruction (REQ→WAIT→VALID→REQ). This requires `req_ready`=1 in REQ, `resp_valid` in the first WAIT cycle, and `inst_ready` in the first VALID cycle.
- A response is never accepted in the same cycle as its request.
- `io_inst_count` is visible one cycle after the retire edge.
- `io_fault` and `io_halted` are registered: they assert the cycle after the causing event.

## Structure
- Shared package `ysyx_25030077_pkg` holds:
  - the state enum (REQ/WAIT/VALID/HALT, 2-bit);
  - the fault code constants (`FAULT_NONE`, `FAULT_ILLEGAL`, `FAULT_ACCESS`, `FAULT_MISALIGN`);
  - `NOP_INST`=32'h13;
  - the default `RESET_PC`.
- Sub-module `ysyx_25030077_pc_reg`: 32-bit PC register with async reset to `RESET_PC` and a write-enable. All other logic stays in the IFU top.

## Test plan
- Reset release, memory always ready, 1-cycle response, `inst_ready`=1, `pc_next`=pc+4 → requests at 0x8000_0000, 0x8000_0004, 0x8000_0008 spaced 3 cycles apart; `io_inst_count`=3 after the third retire.
- `req_ready` held low for 4 cycles, then `resp_valid` delayed 5 cycles → addr held stable throughout; `io_instruction`=`resp_data` (e.g. 0x00500093) once in VALID; no retire while `inst_ready`=0.
- Branch: `pc_next`=0x8000_0100 on retire → next request addr=0x8000_0100, count+1.
- `io_is_unknown_instruction`=1 with `inst_ready`=1 → next cycle `io_halted`=1, `io_fault`=1, pc unchanged, no further requests for 20 cycles.
- `resp_err`=1 → HALT with `io_fault`=2. Separately, `pc_next`=0x8000_0002 → HALT with `io_fault`=3 and count unchanged.
- `reset` pulsed while in WAIT, with a stale response arriving afterwards → pc=0x8000_0000, the stale response is ignored, and a fresh request is issued.
